// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit channel between N byte-stream requesters.
//   Round-robin arbitration; the owner keeps the channel for one packet,
//   ending at its last-flagged byte or after MAX_BURST bytes. Each grant
//   can be prefixed with a channel-ID header byte (HEADER_BASE | index).
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   req_valid     [N]    per-requester byte available
//   req_data      [8N]   per-requester byte, requester i on [8i+7:8i]
//   req_last      [N]    marks the byte on req_data as end of packet
//   req_ready     [N]    per-requester accept (valid & ready = transfer)
//   grant         [N]    one-hot current owner, zero when idle
//   busy                 high whenever a grant is active
//   uart_tx_data  [8]    byte to the uart wrapper (registered)
//   uart_tx_wr           single-cycle write strobe (registered)
//   uart_tx_flag         1 = uart transmitter idle
module uart_tx_arbiter #(
    parameter int         N           = 4,
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BASE = 8'hF0,
    parameter int         MAX_BURST   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [7:0]     uart_tx_data,
    output logic           uart_tx_wr,
    input  logic           uart_tx_flag
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t           state_q;
    logic [N-1:0]     grant_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_idx_q;
    logic [7:0]       burst_q;
    logic             last_q;
    logic             hdr_q;
    logic [7:0]       tx_data_q;
    logic             tx_wr_q;

    logic [IDX_W-1:0] sel_idx_d;
    logic             any_valid;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       owner_data;

    // Round-robin pick: scan last_idx+1 .. last_idx+N (mod N). The loop
    // runs from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        sel_idx_d = last_idx_q;
        for (int k = N; k >= 1; k--) begin
            if (req_valid[(int'(last_idx_q) + k) % N]) begin
                sel_idx_d = IDX_W'((int'(last_idx_q) + k) % N);
            end
        end
    end

    assign any_valid   = |req_valid;
    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_data  = req_data[8*owner_q +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_idx_q <= IDX_W'(N - 1);
            burst_q    <= '0;
            last_q     <= 1'b0;
            hdr_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_wr_q    <= 1'b0;
        end else begin
            // Write strobe is a one-cycle pulse unless re-armed below.
            tx_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_valid && uart_tx_flag) begin
                        owner_q <= sel_idx_d;
                        grant_q <= {{(N-1){1'b0}}, 1'b1} << sel_idx_d;
                        burst_q <= '0;
                        last_q  <= 1'b0;
                        if (HEADER_EN) begin
                            tx_data_q <= HEADER_BASE | 8'(sel_idx_d);
                            tx_wr_q   <= 1'b1;
                            hdr_q     <= 1'b1;
                            state_q   <= WAIT_LO;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    // A stalled owner keeps the grant; nobody preempts it.
                    if (owner_valid) begin
                        tx_data_q <= owner_data;
                        tx_wr_q   <= 1'b1;
                        burst_q   <= burst_q + 8'd1;
                        last_q    <= owner_last;
                        state_q   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // The strobe cycle lands here too, which absorbs the
                    // wrapper's one-cycle lag before tx_flag drops.
                    if (!uart_tx_flag) begin
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (uart_tx_flag) begin
                        if (hdr_q) begin
                            hdr_q   <= 1'b0;
                            state_q <= DATA;
                        end else if (last_q || (burst_q == 8'(MAX_BURST))) begin
                            last_idx_q <= owner_q;
                            grant_q    <= '0;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign req_ready    = (state_q == DATA) ? grant_q : '0;
    assign uart_tx_data = tx_data_q;
    assign uart_tx_wr   = tx_wr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a packet-level reference model predicts the
// byte stream seen by the UART; directed steps cover reset, bursting,
// stalls, mid-operation reset and the header-less variant.
module tb_uart_tx_arbiter;
    localparam int         N  = 4;
    localparam int         MB = 3;
    localparam logic [7:0] HB = 8'hF0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           busy, uart_tx_wr, uart_tx_flag;
    logic [7:0]     uart_tx_data;

    logic [N-1:0]   h0_valid, h0_last, h0_ready, h0_grant;
    logic [8*N-1:0] h0_data;
    logic           h0_busy, h0_wr, h0_flag;
    logic [7:0]     h0_txd;

    uart_tx_arbiter #(.N(N), .HEADER_EN(1'b1), .HEADER_BASE(HB), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
        .uart_tx_data(uart_tx_data), .uart_tx_wr(uart_tx_wr), .uart_tx_flag(uart_tx_flag));

    uart_tx_arbiter #(.N(N), .HEADER_EN(1'b0), .HEADER_BASE(HB), .MAX_BURST(MB)) dut_h0 (
        .clk(clk), .reset(reset), .req_valid(h0_valid), .req_data(h0_data),
        .req_last(h0_last), .req_ready(h0_ready), .grant(h0_grant), .busy(h0_busy),
        .uart_tx_data(h0_txd), .uart_tx_wr(h0_wr), .uart_tx_flag(h0_flag));

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q[N][$];          // per-requester pending bytes {last, data}
    logic [7:0] expq[$];
    logic [7:0] obs[$];
    logic       pend_drop;
    int         busy_cnt;
    logic       prev_wr;
    logic       hold0;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && !(hold0 && i == 0)) begin
                e = q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = e[7:0];
                req_last[i]        = e[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    // One clock: advance the UART model, log writes, check invariants,
    // retire transferred bytes and present the next ones.
    task automatic step();
        logic [N-1:0] xfer;
        xfer = req_valid & req_ready;
        @(posedge clk); #1;
        if (pend_drop) begin
            uart_tx_flag = 1'b0;
            busy_cnt     = $urandom_range(2, 6);
        end else if (!uart_tx_flag) begin
            busy_cnt--;
            if (busy_cnt <= 0) uart_tx_flag = 1'b1;
        end
        pend_drop = uart_tx_wr;
        if (uart_tx_wr) begin
            obs.push_back(uart_tx_data);
            check("wr_spacing", prev_wr, 1'b0);
            check("wr_when_uart_idle", uart_tx_flag, 1'b1);
        end
        prev_wr = uart_tx_wr;
        check("grant_onehot", ($countones(grant) <= 1), 1'b1);
        check("busy_vs_grant", busy, (grant != '0));
        check("ready_within_grant", req_ready & ~grant, '0);
        for (int i = 0; i < N; i++) begin
            if (xfer[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        drive();
    endtask

    // Packet-level prediction: round-robin over requesters that still hold
    // bytes, header first, then bytes up to end of packet or the burst cap.
    task automatic model();
        logic [8:0] m[N][$];
        logic [8:0] e;
        int ptr, sel, cnt;
        bit done;
        for (int i = 0; i < N; i++) m[i] = q[i];
        expq.delete();
        ptr  = N - 1;
        done = 1'b0;
        while (!done) begin
            sel = -1;
            for (int k = N; k >= 1; k--) if (m[(ptr + k) % N].size() > 0) sel = (ptr + k) % N;
            if (sel < 0) begin
                done = 1'b1;
            end else begin
                expq.push_back(HB | 8'(sel));
                cnt = 0;
                do begin
                    e = m[sel].pop_front();
                    expq.push_back(e[7:0]);
                    cnt++;
                end while (!e[8] && cnt < MB);
                ptr = sel;
            end
        end
    endtask

    task automatic run(input int budget, input logic [N-1:0] exp_g);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            if (exp_g != '0 && busy) check("grant_held", grant, exp_g);
            done = all_empty() && !busy && uart_tx_flag && !pend_drop;
        end
        check("run_complete", done, 1'b1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_byte_count"}, obs.size(), expq.size());
        for (int i = 0; i < obs.size() && i < expq.size(); i++)
            check({tag, "_byte"}, obs[i], expq[i]);
        obs.delete();
    endtask

    task automatic clear_bench();
        hold0 = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        uart_tx_flag = 1'b1;
        pend_drop    = 1'b0;
        busy_cnt     = 0;
        prev_wr      = 1'b0;
        h0_valid = '0; h0_last = '0; h0_data = '0; h0_flag = 1'b1;
        drive();
        obs.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_bench();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n, rdy, wrs, xf, fl;
        logic x, pend1;

        // Reset values
        reset = 1'b1;
        clear_bench();
        @(posedge clk); #1;
        check("rst_grant", grant, '0);
        check("rst_ready", req_ready, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr", uart_tx_wr, 1'b0);
        check("rst_data", uart_tx_data, 8'h00);
        check("rst_h0_grant", h0_grant, '0);
        do_reset();

        // Single requester 2: F2, 41, 42
        q[2].push_back(9'h041); q[2].push_back(9'h142);
        model(); drive();
        run(300, 4'b0100);
        check("t1_first", obs[0], 8'hF2);
        compare("t1");
        check("t1_grant_after", grant, '0);
        check("t1_busy_after", busy, 1'b0);

        // Requesters 0 and 1 competing, r0 has a second packet
        do_reset();
        q[0].push_back(9'h0A1); q[0].push_back(9'h1A2);
        q[0].push_back(9'h0A3); q[0].push_back(9'h1A4);
        q[1].push_back(9'h0B1); q[1].push_back(9'h1B2);
        model(); drive();
        run(600, '0);
        compare("t2");

        // Burst cap of 3 splits a 5-byte packet from requester 3
        do_reset();
        for (int b = 1; b <= 5; b++) q[3].push_back({(b == 5), 8'hC0 + 8'(b)});
        model(); drive();
        run(600, 4'b1000);
        compare("t3");

        // Owner stalls mid-packet while requester 1 waits
        do_reset();
        q[0].push_back(9'h041); q[0].push_back(9'h142);
        q[1].push_back(9'h151);
        model(); drive();
        n = 0;
        while (obs.size() < 2 && n < 100) begin step(); n++; end
        check("t4_reach_stall", obs.size(), 2);
        hold0 = 1'b1;
        req_valid[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("t4_grant_kept", grant, 4'b0001);
            check("t4_no_wr", uart_tx_wr, 1'b0);
            check("t4_r1_not_ready", req_ready[1], 1'b0);
        end
        check("t4_owner_ready", req_ready[0], 1'b1);
        hold0 = 1'b0;
        drive();
        run(300, '0);
        compare("t4");

        // Randomized traffic
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
                        int len;
                        len = $urandom_range(1, 5);
                        for (int b = 0; b < len; b++) q[i].push_back({(b == len - 1), 8'($urandom)});
                    end
                end
            end
            model(); drive();
            run(4000, '0);
            compare("rand");
        end

        // Reset while in WAIT_HI; afterwards requester 0 goes first again
        do_reset();
        q[1].push_back(9'h1A1);
        q[2].push_back(9'h0B1); q[2].push_back(9'h1B2);
        drive();
        n = 0;
        while (obs.size() < 4 && n < 200) begin step(); n++; end
        check("t6_reach", obs.size(), 4);
        if (obs.size() >= 4) begin
            check("t6_b0", obs[0], 8'hF1);
            check("t6_b1", obs[1], 8'hA1);
            check("t6_b2", obs[2], 8'hF2);
            check("t6_b3", obs[3], 8'hB1);
        end
        n = 0;
        while (uart_tx_flag && n < 10) begin step(); n++; end
        check("t6_flag_low", uart_tx_flag, 1'b0);
        step();
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_grant", grant, '0);
        check("t6_busy", busy, 1'b0);
        check("t6_wr", uart_tx_wr, 1'b0);
        check("t6_ready", req_ready, '0);
        reset = 1'b0;
        clear_bench();
        q[0].push_back(9'h181);
        q[3].push_back(9'h191);
        model(); drive();
        run(300, '0);
        check("t6_first_after_reset", (expq.size() > 0 && obs.size() > 0) ? obs[0] : 8'h00, 8'hF0);
        compare("t6");

        // Header-less variant: one byte, one strobe, ready on transfer only
        do_reset();
        h0_data[7:0] = 8'h55;
        h0_last      = 4'b0001;
        h0_valid     = 4'b0001;
        h0_flag      = 1'b1;
        rdy = 0; wrs = 0; xf = 0; fl = 0; pend1 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            x = h0_valid[0] & h0_ready[0];
            if (h0_ready[0]) rdy++;
            @(posedge clk); #1;
            if (x) begin
                xf++;
                h0_valid = '0;
            end
            if (pend1) begin
                h0_flag = 1'b0;
                fl = 3;
            end else if (fl > 0) begin
                fl--;
                if (fl == 0) h0_flag = 1'b1;
            end
            pend1 = h0_wr;
            if (h0_wr) begin
                wrs++;
                check("h0_data", h0_txd, 8'h55);
            end
        end
        check("h0_ready_cycles", rdy, 1);
        check("h0_transfers", xf, 1);
        check("h0_wr_pulses", wrs, 1);
        check("h0_busy_after", h0_busy, 1'b0);
        check("h0_grant_after", h0_grant, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit channel of the uart wrapper between N byte-stream requesters.
- Round-robin arbitration between requesters. A granted requester holds the channel for one packet, ending at its last-flagged byte or at MAX_BURST bytes, whichever comes first.
- Optionally prefixes each grant with a channel-ID header byte.
- Sits between on-chip message sources (debug, status, console) and the uart wrapper's tx_data / tx_wr / tx_flag port.

Parameters:
- N, 4: number of requesters (2..8).
- HEADER_EN, 1: 1 = send header byte (HEADER_BASE | index) before the first data byte of each grant.
- HEADER_BASE, 8'hF0: header base value; low bits [2:0] carry the requester index.
- MAX_BURST, 16: maximum data bytes per grant (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N  per-requester byte available
- req_data  in  8*N  per-requester byte; requester i on bits [8i+7:8i]
- req_last  in  N  qualifies the byte on req_data as the final byte of the packet
- req_ready  out  N  per-requester accept; a transfer occurs when req_valid[i] & req_ready[i]
- grant  out  N  one-hot current owner; all zero when IDLE
- busy  out  1  high in any state other than IDLE
- uart_tx_data  out  8  to uart tx_data (registered)
- uart_tx_wr  out  1  to uart tx_wr; single-cycle pulse (registered)
- uart_tx_flag  in  1  from uart tx_flag; 1 = transmitter idle. Drops the cycle after tx_wr and returns to 1 after the byte completes.

Behaviour:
- Reset values: state = IDLE; grant = 0; req_ready = 0; busy = 0; uart_tx_wr = 0; uart_tx_data = 8'h00; burst count = 0; rr pointer last_idx = N-1, so requester 0 wins first.
- States:
  - IDLE: no grant.
  - DATA: waiting for a byte from the owner.
  - WAIT_LO: waiting for uart_tx_flag = 0.
  - WAIT_HI: waiting for uart_tx_flag = 1.
- IDLE:
  - Acts when any req_valid = 1 and uart_tx_flag = 1.
  - Selects the first valid index scanning last_idx+1, last_idx+2, ... modulo N, and registers it into grant; burst count cleared.
  - If HEADER_EN = 1: same edge loads uart_tx_data = HEADER_BASE | idx and sets uart_tx_wr; next state WAIT_LO with hdr flag set.
  - If HEADER_EN = 0: next state DATA.
  - With uart_tx_flag = 0, the block stays in IDLE.
- DATA:
  - req_ready[owner] = 1; all other req_ready = 0.
  - On transfer: uart_tx_data <= req_data[owner], uart_tx_wr <= 1 for the next cycle only, burst count +1, capture req_last; next state WAIT_LO.
  - If the owner deasserts valid, the grant is held indefinitely; this is a requester obligation, not an error.
- WAIT_LO: go to WAIT_HI on the first cycle uart_tx_flag = 0. The tx_wr cycle itself is spent in WAIT_LO, which covers the wrapper's one-cycle flag delay.
- WAIT_HI: on uart_tx_flag = 1:
  - If hdr flag set: clear it, go to DATA.
  - Else if the captured last = 1 or burst count = MAX_BURST: last_idx <= owner, grant <= 0, go to IDLE.
  - Else: go to DATA.
- Latency:
  - Idle to first header tx_wr pulse: 1 cycle after req_valid is seen in IDLE.
  - Data transfer to tx_wr: 1 cycle.
  - uart_tx_wr is never high on two consecutive cycles. At most one byte is outstanding at the UART.
- Boundary conditions:
  - MAX_BURST reached without last: the grant is released. The requester must re-arbitrate; a header is resent if enabled.
  - Simultaneous requests: round-robin only, no fixed priority except the reset start point.
  - A request arriving while another requester owns the channel waits; it is never preempted.
  - Reset mid-operation: immediate return to reset values. An in-flight UART byte is abandoned; the uart wrapper shares the same reset.
  - req_last is ignored on non-transfer cycles.
  - Burst count width: 8 bits.

Test Plan:
- Single requester, N=4, HEADER_EN=1: req 2 sends bytes 41, 42(last) -> uart_tx_wr pulses carry F2, 41, 42; each pulse waits for tx_flag low then high; grant=4'b0100 throughout, then 0; busy low after.
- Requesters 0 and 1 both valid from reset, 2-byte packets -> order F0, r0 bytes, F1, r1 bytes; a third packet from r0 follows r1's packet.
- MAX_BURST=3, requester 3 streams 5 bytes with last only on byte 5 -> F3, b1, b2, b3, release; re-grant then F3, b4, b5.
- HEADER_EN=0, requester 0 byte 55(last) -> exactly one uart_tx_wr pulse, data 55; req_ready[0] high exactly on the transfer cycle.
- Owner drops req_valid for 10 cycles mid-packet while requester 1 is valid -> grant unchanged, no tx_wr, req_ready[1]=0; transfer resumes when valid returns.
- Reset asserted in WAIT_HI -> next cycle state IDLE, grant=0, uart_tx_wr=0; after release, requester 0 is served first.
